// File: rtl/qsfp_port_manager_if.sv
// rtl/qsfp_port_manager_if.sv - QSFP cage sideband and per-channel status bundle
interface qsfp_port_manager_if #(
  parameter int CHANNEL_COUNT = 2
);
  logic [CHANNEL_COUNT-1:0]   modprsl;
  logic [CHANNEL_COUNT-1:0]   force_reset;
  logic [CHANNEL_COUNT-1:0]   run;
  logic [CHANNEL_COUNT-1:0]   resetl;
  logic [CHANNEL_COUNT-1:0]   hpd;
  logic [CHANNEL_COUNT-1:0]   led_y;
  logic [CHANNEL_COUNT-1:0]   led_g;
  logic [2*CHANNEL_COUNT-1:0] state;

  modport master (
    output modprsl, force_reset, run,
    input  resetl, hpd, led_y, led_g, state
  );

  modport slave (
    input  modprsl, force_reset, run,
    output resetl, hpd, led_y, led_g, state
  );
endinterface

// File: rtl/qsfp_port_manager.sv
// rtl/qsfp_port_manager.sv - per-channel QSFP presence debounce, reset sequencing, hpd and LEDs
// Define QSFP_PORT_MANAGER_BLINK_EN to blink led_y during RESET/INIT instead of holding it steady.
module qsfp_port_manager #(
  parameter int CHANNEL_COUNT   = 2,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int RESET_CYCLES    = 200_000,
  parameter int INIT_CYCLES     = 400_000_000,
  parameter int BLINK_CYCLES    = 50_000_000
) (
  input logic                system_clock,
  input logic                system_reset_n,
  qsfp_port_manager_if.slave port
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    ABSENT = 2'd0,
    RESET  = 2'd1,
    INIT   = 2'd2,
    READY  = 2'd3
  } ch_state_t;

  logic seq_led;

`ifdef QSFP_PORT_MANAGER_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge system_clock) begin
    if (!system_reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  assign seq_led = blink_phase;
`else
  localparam bit unused_blink_cycles = (BLINK_CYCLES >= 1);
  assign seq_led = 1'b1;
`endif

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
    logic [1:0]       sync;
    logic             present_raw;
    logic             debounced;
    logic [DEB_W-1:0] deb_cnt;
    ch_state_t        cur;
    ch_state_t        nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             resetl_q;
    logic             hpd_q;
    logic             led_y_q;
    logic             led_g_q;

    // Synchroniser resets to "absent" so a cold start never sees a phantom insertion.
    assign present_raw = ~sync[1];

    always_ff @(posedge system_clock) begin
      if (!system_reset_n) begin
        sync      <= 2'b11;
        debounced <= 1'b0;
        deb_cnt   <= '0;
      end else begin
        sync <= {sync[0], port.modprsl[i]};
        if (present_raw == debounced) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          debounced <= present_raw;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end

    always_comb begin
      nxt       = cur;
      timer_nxt = timer;
      case (cur)
        ABSENT: begin
          timer_nxt = '0;
          if (debounced) nxt = RESET;
        end
        RESET: begin
          if (timer == TMR_W'(RESET_CYCLES - 1)) begin
            nxt       = INIT;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        INIT: begin
          if (port.force_reset[i]) begin
            nxt       = RESET;
            timer_nxt = '0;
          end else if (timer == TMR_W'(INIT_CYCLES - 1)) begin
            nxt       = READY;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        READY: begin
          if (port.force_reset[i]) begin
            nxt       = RESET;
            timer_nxt = '0;
          end
        end
      endcase
      // Removal overrides everything, including a concurrent force_reset.
      if (!debounced) begin
        nxt       = ABSENT;
        timer_nxt = '0;
      end
    end

    always_ff @(posedge system_clock) begin
      if (!system_reset_n) begin
        cur      <= ABSENT;
        timer    <= '0;
        resetl_q <= 1'b0;
        hpd_q    <= 1'b0;
        led_y_q  <= 1'b0;
        led_g_q  <= 1'b0;
      end else begin
        cur      <= nxt;
        timer    <= timer_nxt;
        resetl_q <= (nxt == INIT) || (nxt == READY);
        hpd_q    <= (nxt == READY);
        led_g_q  <= (nxt == READY) && port.run[i];
        led_y_q  <= ((nxt == RESET) || (nxt == INIT)) ? seq_led
                                                      : ((nxt == READY) && !port.run[i]);
      end
    end

    assign port.resetl[i]       = resetl_q;
    assign port.hpd[i]          = hpd_q;
    assign port.led_y[i]        = led_y_q;
    assign port.led_g[i]        = led_g_q;
    assign port.state[2*i +: 2] = cur;
  end

endmodule

// File: tb/tb_qsfp_port_manager.sv
// tb/tb_qsfp_port_manager.sv - directed self-checking bench for qsfp_port_manager
module tb_qsfp_port_manager;

  logic system_clock = 1'b0;
  logic system_reset_n;
  int   total = 0;
  int   bad   = 0;

  qsfp_port_manager_if #(.CHANNEL_COUNT(2)) bus ();

  qsfp_port_manager #(
    .CHANNEL_COUNT  (2),
    .DEBOUNCE_CYCLES(4),
    .RESET_CYCLES   (8),
    .INIT_CYCLES    (16),
    .BLINK_CYCLES   (5)
  ) dut (
    .system_clock  (system_clock),
    .system_reset_n(system_reset_n),
    .port          (bus.slave)
  );

  always #5 system_clock = ~system_clock;

  task automatic step(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_resetl"}, 32'(bus.resetl), 32'h0);
    chk({tag, "_hpd"},    32'(bus.hpd),    32'h0);
    chk({tag, "_led_y"},  32'(bus.led_y),  32'h0);
    chk({tag, "_led_g"},  32'(bus.led_g),  32'h0);
    chk({tag, "_state"},  32'(bus.state),  32'h0);
  endtask

  logic [14:0] ly;
  int          first;
  int          toggles;

  initial begin
    system_reset_n  = 1'b0;
    bus.modprsl     = 2'b11;
    bus.force_reset = 2'b00;
    bus.run         = 2'b00;
    step(3);
    chk_reset_vals("reset");
    system_reset_n = 1'b1;
    step(2);
    chk_reset_vals("idle");

    // insertion on channel 0
    bus.modprsl = 2'b10;
    step(6);
    chk("ins_not_yet", 32'(bus.state), 32'h0);
    step(1);
    chk("ins_state_reset", 32'(bus.state[1:0]), 32'd1);
    chk("ins_resetl_low", 32'(bus.resetl[0]), 32'd0);
`ifndef QSFP_PORT_MANAGER_BLINK_EN
    chk("ins_led_y_steady", 32'(bus.led_y[0]), 32'd1);
`endif
    step(7);
    chk("reset_hold_8", 32'({bus.resetl[0], bus.state[1:0]}), 32'b0_01);
    step(1);
    chk("resetl_rise", 32'({bus.resetl[0], bus.state[1:0]}), 32'b1_10);
    for (int k = 0; k < 15; k++) begin
      step(1);
      ly[k] = bus.led_y[0];
    end
    chk("init_hpd_low", 32'(bus.hpd[0]), 32'd0);
`ifdef QSFP_PORT_MANAGER_BLINK_EN
    first = -1;
    for (int k = 1; k < 15; k++)
      if (first < 0 && ly[k] != ly[k-1]) first = k;
    chk("blink_first_toggle", 32'(first > 0 && first <= 5), 32'd1);
    if (first > 0 && first <= 5) begin
      toggles = 0;
      for (int k = first + 1; k <= first + 4; k++)
        if (ly[k] != ly[k-1]) toggles++;
      chk("blink_hold_5", 32'(toggles), 32'd0);
      chk("blink_toggle_5", 32'(ly[first+5] != ly[first+4]), 32'd1);
    end
`else
    chk("init_led_y_steady", 32'(ly), 32'h7fff);
`endif
    step(1);
    chk("hpd_rise_16", 32'({bus.hpd[0], bus.state[1:0]}), 32'b1_11);
    chk("ch1_absent", 32'({bus.resetl[1], bus.hpd[1], bus.state[3:2]}), 32'h0);

    // 3-cycle glitch on channel 1
    bus.modprsl = 2'b00;
    step(3);
    bus.modprsl = 2'b10;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("glitch_ch1", 32'({bus.resetl[1], bus.hpd[1], bus.state[3:2]}), 32'h0);
    end

    // LEDs in READY follow run with one cycle latency
    chk("ready_run0", 32'({bus.led_y[0], bus.led_g[0]}), 32'b10);
    bus.run = 2'b01;
    #1;
    chk("run_latency", 32'({bus.led_y[0], bus.led_g[0]}), 32'b10);
    step(1);
    chk("ready_run1", 32'({bus.led_y[0], bus.led_g[0]}), 32'b01);
    chk("ch1_no_led", 32'({bus.led_y[1], bus.led_g[1]}), 32'b00);
    bus.run = 2'b00;
    step(1);
    chk("ready_run0_again", 32'({bus.led_y[0], bus.led_g[0]}), 32'b10);

    // force_reset from READY
    bus.force_reset = 2'b01;
    step(1);
    bus.force_reset = 2'b00;
    chk("force_hpd_drop", 32'({bus.hpd[0], bus.resetl[0], bus.state[1:0]}), 32'b0_0_01);
    step(7);
    chk("force_hold_8", 32'({bus.resetl[0], bus.state[1:0]}), 32'b0_01);
    step(1);
    chk("force_release", 32'({bus.resetl[0], bus.state[1:0]}), 32'b1_10);
    step(16);
    chk("force_ready", 32'({bus.hpd[0], bus.state[1:0]}), 32'b1_11);

    // removal from READY
    bus.modprsl = 2'b11;
    step(6);
    chk("rem_not_yet", 32'(bus.hpd[0]), 32'd1);
    step(1);
    chk("rem_done", 32'({bus.hpd[0], bus.resetl[0], bus.state[1:0]}), 32'h0);

    // removal and force_reset in the same cycle
    bus.modprsl = 2'b10;
    step(7 + 8 + 16);
    chk("reins_ready", 32'(bus.state[1:0]), 32'd3);
    bus.modprsl = 2'b11;
    step(6);
    chk("race_pre", 32'(bus.state[1:0]), 32'd3);
    bus.force_reset = 2'b01;
    step(1);
    bus.force_reset = 2'b00;
    chk("race_absent", 32'({bus.hpd[0], bus.resetl[0], bus.state[1:0]}), 32'h0);
    step(3);
    chk("race_stays_absent", 32'(bus.state[1:0]), 32'd0);

    // system reset while channel 0 is in INIT
    bus.modprsl = 2'b10;
    bus.run     = 2'b11;
    step(7 + 8 + 3);
    chk("pre_rst_init", 32'({bus.resetl[0], bus.state[1:0]}), 32'b1_10);
    system_reset_n = 1'b0;
    step(1);
    chk_reset_vals("mid_rst");
    system_reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
